// File: rtl/msi_bus_arbiter_if.sv
// Bundle of request, snoop broadcast, memory and completion signals around the MSI bus arbiter.
// The arbiter side uses the master modport; the cores and the memory use slave.
interface msi_bus_arbiter_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IDX_W     = 2
) ();
    logic [NUM_CORES-1:0]        req;
    logic [2*NUM_CORES-1:0]      req_op;
    logic [ADDR_W*NUM_CORES-1:0] req_addr;
    logic [DATA_W*NUM_CORES-1:0] req_wdata;
    logic [NUM_CORES-1:0]        gnt;
    logic                        bus_valid;
    logic [1:0]                  bus_op;
    logic [ADDR_W-1:0]           bus_addr;
    logic [IDX_W-1:0]            bus_src;
    logic [NUM_CORES-1:0]        snoop_ack;
    logic [NUM_CORES-1:0]        snoop_flush;
    logic [DATA_W*NUM_CORES-1:0] snoop_data;
    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_ready;
    logic [NUM_CORES-1:0]        done;
    logic [DATA_W-1:0]           resp_data;

    modport master (
        input  req, req_op, req_addr, req_wdata,
        input  snoop_ack, snoop_flush, snoop_data,
        input  mem_rdata, mem_ready,
        output gnt, bus_valid, bus_op, bus_addr, bus_src,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output done, resp_data
    );

    modport slave (
        output req, req_op, req_addr, req_wdata,
        output snoop_ack, snoop_flush, snoop_data,
        output mem_rdata, mem_ready,
        input  gnt, bus_valid, bus_op, bus_addr, bus_src,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  done, resp_data
    );
endinterface

// File: rtl/msi_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared MSI snooping bus: grant, snoop broadcast,
// optional memory access, then a one-cycle done pulse with the line data.
module msi_bus_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IDX_W     = 2
) (
    input logic              clk,
    input logic              resetn,
    msi_bus_arbiter_if.master bus
);

    localparam logic [1:0] OpBusRd   = 2'b00;
    localparam logic [1:0] OpBusRdX  = 2'b01;
    localparam logic [1:0] OpBusUpgr = 2'b10;
    localparam logic [1:0] OpFlush   = 2'b11;

    typedef enum logic [1:0] {StIdle, StSnoop, StMem, StDone} state_e;

    state_e               state_q;
    logic [NUM_CORES-1:0] gnt_q;
    logic                 bus_valid_q;
    logic [1:0]           bus_op_q;
    logic [ADDR_W-1:0]    bus_addr_q;
    logic [IDX_W-1:0]     bus_src_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [NUM_CORES-1:0] done_q;
    logic [DATA_W-1:0]    resp_data_q;
    logic [NUM_CORES-1:0] ack_q;
    logic [NUM_CORES-1:0] flush_q;
    logic [DATA_W-1:0]    flush_data_q;
    logic [IDX_W-1:0]     last_winner_q;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_CORES-1:0] win_onehot;
    logic [1:0]           win_op;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;

    logic [NUM_CORES-1:0] own_mask;
    logic [NUM_CORES-1:0] ack_new;
    logic [NUM_CORES-1:0] flush_new;
    logic                 all_acked;
    logic                 flush_any;
    logic [DATA_W-1:0]    flush_data_d;

    // Search upward from the core after the last winner, wrapping around.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_op     = '0;
        win_addr   = '0;
        win_wdata  = '0;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            int unsigned idx;
            idx = (32'(last_winner_q) + k) % NUM_CORES;
            if (!win_found && bus.req[idx]) begin
                win_found       = 1'b1;
                win_idx         = IDX_W'(idx);
                win_onehot      = '0;
                win_onehot[idx] = 1'b1;
                win_op          = bus.req_op[2*idx +: 2];
                win_addr        = bus.req_addr[ADDR_W*idx +: ADDR_W];
                win_wdata       = bus.req_wdata[DATA_W*idx +: DATA_W];
            end
        end
    end

    always_comb begin
        own_mask  = {{(NUM_CORES-1){1'b0}}, 1'b1} << bus_src_q;
        ack_new   = bus.snoop_ack & ~own_mask;
        flush_new = bus.snoop_ack & bus.snoop_flush & ~own_mask;
        all_acked = &(ack_q | ack_new | own_mask);
        flush_any = |(flush_q | flush_new);
    end

    // Lowest-index flusher wins; its data is taken only on the cycle its ack first arrives.
    always_comb begin
        logic found;
        found        = 1'b0;
        flush_data_d = flush_data_q;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!found && (flush_q[i] || flush_new[i])) begin
                found = 1'b1;
                if (flush_new[i] && !flush_q[i]) begin
                    flush_data_d = bus.snoop_data[DATA_W*i +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            gnt_q         <= '0;
            bus_valid_q   <= 1'b0;
            bus_op_q      <= '0;
            bus_addr_q    <= '0;
            bus_src_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            done_q        <= '0;
            resp_data_q   <= '0;
            ack_q         <= '0;
            flush_q       <= '0;
            flush_data_q  <= '0;
            last_winner_q <= IDX_W'(NUM_CORES - 1);
        end else begin
            done_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        gnt_q        <= win_onehot;
                        bus_src_q    <= win_idx;
                        bus_op_q     <= win_op;
                        bus_addr_q   <= win_addr;
                        ack_q        <= '0;
                        flush_q      <= '0;
                        flush_data_q <= '0;
                        resp_data_q  <= '0;
                        if (win_op == OpFlush) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= win_addr;
                            mem_wdata_q <= win_wdata;
                            state_q     <= StMem;
                        end else begin
                            bus_valid_q <= 1'b1;
                            state_q     <= StSnoop;
                        end
                    end
                end
                StSnoop: begin
                    ack_q        <= ack_q | ack_new;
                    flush_q      <= flush_q | flush_new;
                    flush_data_q <= flush_data_d;
                    if (all_acked) begin
                        bus_valid_q <= 1'b0;
                        if (bus_op_q == OpBusUpgr) begin
                            done_q  <= own_mask;
                            state_q <= StDone;
                        end else if (flush_any && bus_op_q == OpBusRdX) begin
                            resp_data_q <= flush_data_d;
                            done_q      <= own_mask;
                            state_q     <= StDone;
                        end else if (flush_any) begin
                            // M->S on BusRd: the owner's data also updates memory.
                            resp_data_q <= flush_data_d;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= bus_addr_q;
                            mem_wdata_q <= flush_data_d;
                            state_q     <= StMem;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= bus_addr_q;
                            state_q    <= StMem;
                        end
                    end
                end
                StMem: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_we_q) begin
                            resp_data_q <= bus.mem_rdata;
                        end
                        done_q  <= own_mask;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    gnt_q         <= '0;
                    last_winner_q <= bus_src_q;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_op    = bus_op_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_src   = bus_src_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.resp_data = resp_data_q;

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Scoreboard bench for msi_bus_arbiter: directed transactions push expectations, and a
// monitor checks grant, memory access, bus_valid/mem_req lengths and the done response.
module tb_msi_bus_arbiter;

    localparam int NC = 4;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_RDX  = 2'b01;
    localparam logic [1:0] OP_UPGR = 2'b10;
    localparam logic [1:0] OP_FL   = 2'b11;

    typedef struct {
        int          core;
        logic [31:0] data;
        int          bv;
        int          mem;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk;
    logic resetn;

    msi_bus_arbiter_if #(.NUM_CORES(4), .ADDR_W(9), .DATA_W(32), .IDX_W(2)) bus ();

    msi_bus_arbiter #(.NUM_CORES(4), .ADDR_W(9), .DATA_W(32), .IDX_W(2)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          ack_dly[NC];
    logic        flush_en[NC];
    logic [31:0] flush_dat[NC];
    int          mem_lat = 2;
    logic [31:0] mem_rd_val = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Snooping caches: each non-requesting core pulses its ack once, ack_dly cycles into SNOOP.
    int snp_k = 0;
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) bus.snoop_data[32*i +: 32] = flush_dat[i];
        if (resetn && bus.bus_valid) begin
            snp_k++;
            for (int i = 0; i < NC; i++) begin
                if (i != int'(bus.bus_src) && snp_k == ack_dly[i]) begin
                    bus.snoop_ack[i]   = 1'b1;
                    bus.snoop_flush[i] = flush_en[i];
                end else begin
                    bus.snoop_ack[i]   = 1'b0;
                    bus.snoop_flush[i] = 1'b0;
                end
            end
        end else begin
            snp_k           = 0;
            bus.snoop_ack   = '0;
            bus.snoop_flush = '0;
        end
    end

    // Memory: mem_ready on the mem_lat-th cycle of mem_req.
    int mem_k = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            bus.mem_ready = 1'b0;
            mem_k = 0;
        end else if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            mem_k = 0;
        end else if (bus.mem_req) begin
            mem_k++;
            if (mem_k == mem_lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_rd_val;
            end
        end else begin
            mem_k = 0;
        end
    end

    // Monitor: compares DUT activity against the head of exp_q.
    int         bv_cnt = 0;
    int         mem_cnt = 0;
    logic [3:0] prev_gnt = '0;
    logic       prev_mem = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            bv_cnt   = 0;
            mem_cnt  = 0;
            prev_gnt = '0;
            prev_mem = 1'b0;
        end else begin
            if (bus.gnt != '0 && prev_gnt == '0) begin
                bv_cnt  = 0;
                mem_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL grant: unexpected gnt %b", bus.gnt);
                end else begin
                    chk("gnt", 32'(bus.gnt), 32'(1) << exp_q[0].core);
                    chk("bus_src", 32'(bus.bus_src), 32'(exp_q[0].core));
                end
            end
            if (bus.bus_valid) bv_cnt++;
            if (bus.mem_req) begin
                if (!prev_mem && exp_q.size() != 0 && exp_q[0].mem > 0) begin
                    chk("mem_we", 32'(bus.mem_we), 32'(exp_q[0].we));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
                    if (exp_q[0].we) chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                end
                mem_cnt++;
            end
            if (bus.done != '0) begin
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL done: unexpected done %b", bus.done);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done", 32'(bus.done), 32'(1) << e.core);
                    chk("gnt_at_done", 32'(bus.gnt), 32'(1) << e.core);
                    chk("resp_data", bus.resp_data, e.data);
                    chk("bus_valid_cycles", 32'(bv_cnt), 32'(e.bv));
                    chk("mem_req_cycles", 32'(mem_cnt), 32'(e.mem));
                end
            end
            prev_gnt = bus.gnt;
            prev_mem = bus.mem_req;
        end
    end

    task automatic expect_txn(input int core, input logic [31:0] data, input int bv, input int mem,
                              input logic we, input logic [8:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.core = core; e.data = data; e.bv = bv; e.mem = mem;
        e.we = we; e.addr = addr; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int core, input logic [1:0] op, input logic [8:0] addr,
                         input logic [31:0] wd);
        bus.req_op[2*core +: 2]     = op;
        bus.req_addr[9*core +: 9]   = addr;
        bus.req_wdata[32*core +: 32] = wd;
        bus.req[core]               = 1'b1;
    endtask

    task automatic wait_done(input int core);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.done[core]) seen = 1'b1;
        end
        if (!seen) begin
            n_tot++;
            $display("FAIL wait_done: no done for core %0d within 200 cycles", core);
        end
        bus.req[core] = 1'b0;
    endtask

    task automatic wait_any_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.done != '0) seen = 1'b1;
        end
        if (!seen) begin
            n_tot++;
            $display("FAIL wait_any_done: no done within 200 cycles");
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'h0);
        chk({tag, ".bus_valid"}, 32'(bus.bus_valid), 32'h0);
        chk({tag, ".bus_op"}, 32'(bus.bus_op), 32'h0);
        chk({tag, ".bus_addr"}, 32'(bus.bus_addr), 32'h0);
        chk({tag, ".bus_src"}, 32'(bus.bus_src), 32'h0);
        chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'h0);
        chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'h0);
        chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'h0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, ".done"}, 32'(bus.done), 32'h0);
        chk({tag, ".resp_data"}, bus.resp_data, 32'h0);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.req       = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NC; i++) begin
            ack_dly[i]   = 1;
            flush_en[i]  = 1'b0;
            flush_dat[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // Round robin with every core requesting BusUpgr continuously.
        for (int i = 0; i < 4; i++) issue(i, OP_UPGR, 9'(i), 32'h0);
        expect_txn(0, 32'h0, 1, 0, 1'b0, 9'h0, 32'h0);
        expect_txn(1, 32'h0, 1, 0, 1'b0, 9'h0, 32'h0);
        expect_txn(2, 32'h0, 1, 0, 1'b0, 9'h0, 32'h0);
        expect_txn(3, 32'h0, 1, 0, 1'b0, 9'h0, 32'h0);
        expect_txn(0, 32'h0, 1, 0, 1'b0, 9'h0, 32'h0);
        for (int n = 0; n < 5; n++) wait_any_done();
        bus.req = '0;
        repeat (2) @(negedge clk);

        // Core0 BusRd, memory read after 3 cycles.
        mem_lat = 3; mem_rd_val = 32'hDEADBEEF;
        expect_txn(0, 32'hDEADBEEF, 1, 3, 1'b0, 9'h015, 32'h0);
        issue(0, OP_RD, 9'h015, 32'h0);
        wait_done(0);

        // Core2 BusRd with core1 holding the line modified: memory update plus response.
        mem_lat = 2; mem_rd_val = 32'hBAD0BAD0;
        flush_en[1] = 1'b1; flush_dat[1] = 32'h12345678;
        expect_txn(2, 32'h12345678, 1, 2, 1'b1, 9'h100, 32'h12345678);
        issue(2, OP_RD, 9'h100, 32'h0);
        wait_done(2);
        @(negedge clk);

        // Same with BusRdX: no memory write.
        expect_txn(2, 32'h12345678, 1, 0, 1'b0, 9'h100, 32'h0);
        issue(2, OP_RDX, 9'h100, 32'h0);
        wait_done(2);
        flush_en[1] = 1'b0;
        @(negedge clk);

        // Core3 writeback skips the snoop phase.
        expect_txn(3, 32'h0, 0, 2, 1'b1, 9'h1FF, 32'hA5A5A5A5);
        issue(3, OP_FL, 9'h1FF, 32'hA5A5A5A5);
        wait_done(3);
        @(negedge clk);

        // Staggered single-cycle acks for requester 2; exit only after core0's late ack.
        ack_dly[0] = 4; ack_dly[1] = 1; ack_dly[3] = 2;
        mem_lat = 1; mem_rd_val = 32'h0BADF00D;
        expect_txn(2, 32'h0BADF00D, 4, 1, 1'b0, 9'h033, 32'h0);
        issue(2, OP_RD, 9'h033, 32'h0);
        wait_done(2);
        for (int i = 0; i < NC; i++) ack_dly[i] = 1;
        @(negedge clk);

        // Reset while core1 is in its memory phase: abort with no done.
        mem_lat = 50;
        expect_txn(1, 32'h0, 1, 1, 1'b0, 9'h0AA, 32'h0);
        issue(1, OP_RD, 9'h0AA, 32'h0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(negedge clk);
                if (bus.mem_req) seen = 1'b1;
            end
            if (!seen) begin
                n_tot++;
                $display("FAIL mid_reset: mem_req for core 1 never seen");
            end
        end
        @(negedge clk);
        resetn  = 1'b0;
        bus.req = '0;
        exp_q.delete();
        @(negedge clk);
        check_zero("mid_reset");
        resetn  = 1'b1;
        mem_lat = 2;

        // After reset core0 has priority over core1.
        expect_txn(0, 32'h0, 1, 0, 1'b0, 9'h0, 32'h0);
        expect_txn(1, 32'h0, 1, 0, 1'b0, 9'h0, 32'h0);
        issue(0, OP_UPGR, 9'h011, 32'h0);
        issue(1, OP_UPGR, 9'h022, 32'h0);
        wait_done(0);
        wait_done(1);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tot++;
            $display("FAIL leftover: %0d expected transactions never completed", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
